// File: rtl/parallel2serial.sv
// Word-to-bitstream serializer with a one-word holding register and a GAP-cycle idle gap between frames.
// Latency: a word accepted at edge N drives its first bit after edge N+1; then WIDTH contiguous valid bits.
// Backpressure: din_ready is the registered inverse of the hold-full flag and is never a function of din_valid.
module parallel2serial #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_parallel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout_serial,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    LAST_GAP = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAPW
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shreg;
    logic             hold_full;
    logic [CW-1:0]    bitcnt;
    logic [3:0]       gapcnt;

    logic             accept;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_next;

    assign accept   = din_valid && din_ready;
    assign last_bit = (state == SHIFT) && (bitcnt == LAST_BIT);

    // Shift toward whichever end feeds dout_serial; vacated bits fill with zero.
    assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg[WIDTH-1:1]};

    // A hold->shreg transfer happens in exactly one of three places.
    always_comb begin
        load = 1'b0;
        unique case (state)
            IDLE:    load = hold_full;
            SHIFT:   load = last_bit && (GAP == 0) && hold_full;
            GAPW:    load = (gapcnt == LAST_GAP) && hold_full;
            default: load = 1'b0;
        endcase
    end

    // accept needs !hold_full and load needs hold_full, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= din_parallel;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        shreg  <= hold;
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg  <= shreg_next;
                    bitcnt <= bitcnt + 1'b1;
                    if (last_bit) begin
                        bitcnt <= '0;
                        if (GAP > 0) begin
                            gapcnt <= '0;
                            state  <= GAPW;
                        end else if (hold_full) begin
                            shreg <= hold;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAPW: begin
                    gapcnt <= gapcnt + 4'd1;
                    if (gapcnt == LAST_GAP) begin
                        if (hold_full) begin
                            shreg  <= hold;
                            bitcnt <= '0;
                            state  <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is held low during reset so nothing is accepted into a register being cleared.
    assign din_ready   = !hold_full && !rst;
    assign dout_valid  = (state == SHIFT);
    assign dout_serial = dout_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign frame_done  = last_bit;
    assign busy        = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_parallel2serial.sv
// Bench for parallel2serial: three instances (MSB/GAP1, LSB/GAP1, MSB/GAP0) driven by a vector table
// plus hand-written sequences for back-to-back, gap, reset-abort and loopback behaviour.
module tb_parallel2serial;

    logic       clk;
    logic       rst  [3];
    logic [7:0] din  [3];
    logic       dv   [3];
    logic       rdy  [3];
    logic       ds   [3];
    logic       dov  [3];
    logic       fd   [3];
    logic       bz   [3];

    int n_vec = 0;
    int n_bad = 0;

    parallel2serial #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1)) u_msb (
        .clk(clk), .rst(rst[0]), .din_parallel(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
        .dout_serial(ds[0]), .dout_valid(dov[0]), .frame_done(fd[0]), .busy(bz[0]));

    parallel2serial #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1)) u_lsb (
        .clk(clk), .rst(rst[1]), .din_parallel(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
        .dout_serial(ds[1]), .dout_valid(dov[1]), .frame_done(fd[1]), .busy(bz[1]));

    parallel2serial #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_g0 (
        .clk(clk), .rst(rst[2]), .din_parallel(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
        .dout_serial(ds[2]), .dout_valid(dov[2]), .frame_done(fd[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // exp holds the bits in emission order, exp[7] first.
    task automatic run_frame(input int d, input logic [7:0] w, input logic [7:0] exp, input string nm);
        int t;
        t = 0;
        while (!rdy[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_ready"}, 32'(rdy[d]), 32'd1);
        din[d] = w;
        dv[d]  = 1'b1;
        @(negedge clk);
        dv[d] = 1'b0;
        chk({nm, "_latency_valid"}, 32'(dov[d]), 32'd0);
        chk({nm, "_ready_full"}, 32'(rdy[d]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("%s_valid%0d", nm, i), 32'(dov[d]), 32'd1);
            chk($sformatf("%s_bit%0d", nm, i), 32'(ds[d]), 32'(exp[7-i]));
            chk($sformatf("%s_done%0d", nm, i), 32'(fd[d]), (i == 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk({nm, "_after_valid"}, 32'(dov[d]), 32'd0);
        chk({nm, "_after_serial"}, 32'(ds[d]), 32'd0);
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(bz[d]), 32'd0);
    endtask

    typedef struct {
        int         d;
        logic [7:0] w;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t        vt [7];
    logic [16:0] seq3;
    logic [23:0] seq4;
    logic [7:0]  w4 [3];
    logic [7:0]  sent [$];
    int          idx;
    logic        acc;
    int          got;
    bit          drv_stop;

    initial begin
        vt[0] = '{0, 8'hA5, 8'b10100101, "msb_a5"};
        vt[1] = '{1, 8'hA5, 8'b10100101, "lsb_a5"};
        vt[2] = '{1, 8'h01, 8'b10000000, "lsb_01"};
        vt[3] = '{0, 8'h96, 8'b10010110, "msb_96"};
        vt[4] = '{1, 8'h96, 8'b01101001, "lsb_96"};
        vt[5] = '{2, 8'h3C, 8'b00111100, "g0_3c"};
        vt[6] = '{1, 8'h80, 8'b00000001, "lsb_80"};

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            din[i] = 8'h00;
            dv[i]  = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_ready", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("rst%0d_valid", i), 32'(dov[i]), 32'd0);
            chk($sformatf("rst%0d_serial", i), 32'(ds[i]), 32'd0);
            chk($sformatf("rst%0d_done", i), 32'(fd[i]), 32'd0);
            chk($sformatf("rst%0d_busy", i), 32'(bz[i]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rel%0d_ready", i), 32'(rdy[i]), 32'd1);
        @(negedge clk);

        for (int v = 0; v < 7; v++) run_frame(vt[v].d, vt[v].w, vt[v].exp, vt[v].nm);

        // Back-to-back with one idle cycle between frames; second word waits in the holding register.
        seq3 = {8'h3C, 1'b0, 8'hC3};
        @(negedge clk);
        din[0] = 8'h3C;
        dv[0]  = 1'b1;
        @(negedge clk);
        chk("t3_ready_full", 32'(rdy[0]), 32'd0);
        chk("t3_latency", 32'(dov[0]), 32'd0);
        din[0] = 8'hC3;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 1) dv[0] = 1'b0;
            chk($sformatf("t3_valid%0d", k), 32'(dov[0]), (k != 8) ? 32'd1 : 32'd0);
            chk($sformatf("t3_bit%0d", k), 32'(ds[0]), 32'(seq3[16-k]));
            chk($sformatf("t3_ready%0d", k), 32'(rdy[0]), (k == 0 || k >= 9) ? 32'd1 : 32'd0);
            chk($sformatf("t3_done%0d", k), 32'(fd[0]), (k == 7 || k == 16) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("t3_idle_busy", 32'(bz[0]), 32'd0);

        // GAP=0 streaming: three words form one unbroken 24-bit run.
        w4[0] = 8'hF0;
        w4[1] = 8'h5A;
        w4[2] = 8'h0F;
        seq4  = {8'hF0, 8'h5A, 8'h0F};
        @(negedge clk);
        idx    = 0;
        din[2] = w4[0];
        dv[2]  = 1'b1;
        acc    = rdy[2];
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) din[2] = w4[idx];
                else dv[2] = 1'b0;
            end
            chk($sformatf("t4_valid%0d", c), 32'(dov[2]), (c >= 2 && c <= 25) ? 32'd1 : 32'd0);
            chk($sformatf("t4_bit%0d", c), 32'(ds[2]),
                (c >= 2 && c <= 25) ? 32'(seq4[25-c]) : 32'd0);
            chk($sformatf("t4_done%0d", c), 32'(fd[2]),
                (c == 9 || c == 17 || c == 25) ? 32'd1 : 32'd0);
            acc = dv[2] && rdy[2];
        end
        chk("t4_words_taken", 32'(idx), 32'd3);

        // Reset during bit 4 of 8'hFF with 8'h55 buffered.
        @(negedge clk);
        din[0] = 8'hFF;
        dv[0]  = 1'b1;
        @(negedge clk);
        din[0] = 8'h55;
        @(negedge clk);
        chk("t5_ready_before_second", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        dv[0] = 1'b0;
        chk("t5_second_buffered", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_bit4_valid", 32'(dov[0]), 32'd1);
        chk("t5_bit4_serial", 32'(ds[0]), 32'd1);
        rst[0] = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(dov[0]), 32'd0);
        chk("t5_rst_serial", 32'(ds[0]), 32'd0);
        chk("t5_rst_ready", 32'(rdy[0]), 32'd0);
        chk("t5_rst_busy", 32'(bz[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        chk("t5_rel_ready", 32'(rdy[0]), 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("t5_quiet_valid%0d", k), 32'(dov[0]), 32'd0);
            chk($sformatf("t5_quiet_busy%0d", k), 32'(bz[0]), 32'd0);
        end

        // Loopback: a bench-side deserializer reassembles MSB-first frames.
        got      = 0;
        drv_stop = 1'b0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 200 && !drv_stop; i++) begin
                    int t;
                    logic [7:0] w;
                    t = 0;
                    while (!rdy[0] && t < 100) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!rdy[0]) begin
                        chk("lb_ready_timeout", 32'(rdy[0]), 32'd1);
                        drv_stop = 1'b1;
                    end else begin
                        w = 8'($urandom_range(0, 255));
                        sent.push_back(w);
                        din[0] = w;
                        dv[0]  = 1'b1;
                        @(negedge clk);
                        dv[0] = 1'b0;
                    end
                end
            end
            begin
                logic [7:0] sh;
                logic [7:0] e;
                int nb;
                nb = 0;
                sh = 8'h00;
                for (int cyc = 0; cyc < 8000 && got < 200 && !drv_stop; cyc++) begin
                    @(negedge clk);
                    if (dov[0]) begin
                        sh = {sh[6:0], ds[0]};
                        nb++;
                        if (nb == 8) begin
                            nb = 0;
                            e  = (sent.size() > 0) ? sent.pop_front() : 8'hxx;
                            chk($sformatf("lb_word%0d", got), 32'(sh), 32'(e));
                            got++;
                        end
                    end
                end
            end
        join
        chk("lb_word_count", 32'(got), 32'd200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
